// File: rtl/pcpi_mem_arbiter.sv
// Round-robin 2:1 arbiter for the PCPI data-memory bus. Each access is atomic; the request is registered toward the slave.
// Optional MEM_ARB_TIMEOUT_EN: a stalled access is aborted after TIMEOUT_CYCLES and returns 0xDEADBEEF.
module pcpi_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              last_grant;  // 1 = master 1 owned the previous access
    logic [1:0]        grant_r;
    logic              req_any, pick_m1, abort, done;
    logic [DATA_W-1:0] rsp_data;

    assign req_any  = m0_valid | m1_valid;
    assign pick_m1  = m1_valid & (~m0_valid | ~last_grant);
    assign done     = (state == BUSY) & (s_ready | abort);
    assign rsp_data = abort ? DATA_W'(32'hDEADBEEF) : s_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             to_err_r;

    // Counts BUSY cycles; zero in every other state, so it is clear on BUSY entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              to_cnt <= '0;
        else if (state != BUSY)   to_cnt <= '0;
        else                      to_cnt <= to_cnt + 1'b1;
    end

    // s_ready on the final cycle takes precedence over the abort.
    assign abort = (state == BUSY) & ~s_ready & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) to_err_r <= 1'b0;
        else         to_err_r <= abort;
    end
    assign timeout_err = to_err_r;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = BUSY;
            BUSY:    if (done)    state_nxt = RESP;
            RESP:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = (state == BUSY);
        m0_ready = (state == RESP) & grant_r[0];
        m1_ready = (state == RESP) & grant_r[1];
    end

    assign grant = grant_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            grant_r    <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    grant_r    <= pick_m1 ? 2'b10 : 2'b01;
                    last_grant <= pick_m1;
                    s_addr     <= pick_m1 ? m1_addr  : m0_addr;
                    s_wdata    <= pick_m1 ? m1_wdata : m0_wdata;
                    s_wstrb    <= pick_m1 ? m1_wstrb : m0_wstrb;
                end
                BUSY: if (done) begin
                    if (grant_r[1]) m1_rdata <= rsp_data;
                    else            m0_rdata <= rsp_data;
                end
                RESP:    grant_r <= 2'b00;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_mem_arbiter.sv
// Bench for pcpi_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pcpi_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [1:0]  mv = 2'b00;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        m0_ready, m1_ready, s_valid, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  mrdy;

    assign mrdy = {m1_ready, m0_ready};

    pcpi_mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which master owns the bus, whether the slave
    // answered yet, and which master sees its one-cycle completion pulse.
    int          e_cur   = -1;
    int          e_pulse = -1;
    int          e_last  = 1;
    logic [31:0] e_addr  = 0, e_wdata = 0;
    logic [3:0]  e_wstrb = 0;
    logic [31:0] e_rd [2] = '{32'h0, 32'h0};
    logic        e_sv;
    logic [1:0]  e_grant;

    function automatic int winner(input logic [1:0] v, input int lst);
        if (v == 2'b11) return 1 - lst;
        return v[1] ? 1 : 0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_cur <= -1; e_pulse <= -1; e_last <= 1;
            e_addr <= 0; e_wdata <= 0; e_wstrb <= 0;
            e_rd[0] <= 0; e_rd[1] <= 0;
        end else if (e_pulse != -1) begin
            e_pulse <= -1;
            e_cur   <= -1;
        end else if (e_cur != -1) begin
            if (s_ready) begin
                e_rd[e_cur] <= s_rdata;
                e_pulse     <= e_cur;
            end
        end else if (mv != 2'b00) begin
            e_cur   <= winner(mv, e_last);
            e_last  <= winner(mv, e_last);
            e_addr  <= ma[winner(mv, e_last)];
            e_wdata <= mw[winner(mv, e_last)];
            e_wstrb <= ms[winner(mv, e_last)];
        end
    end

    assign e_sv    = (e_cur != -1) && (e_pulse == -1);
    assign e_grant = (e_cur == -1) ? 2'b00 : ((e_cur == 1) ? 2'b10 : 2'b01);

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_s_valid", 32'(s_valid), 32'(e_sv));
            chk("mdl_grant", 32'(grant), 32'(e_grant));
            chk("mdl_m0_ready", 32'(m0_ready), 32'(e_pulse == 0));
            chk("mdl_m1_ready", 32'(m1_ready), 32'(e_pulse == 1));
            chk("mdl_timeout_err", 32'(timeout_err), 32'h0);
            chk("mdl_m0_rdata", m0_rdata, e_rd[0]);
            chk("mdl_m1_rdata", m1_rdata, e_rd[1]);
            if (e_sv) begin
                chk("mdl_s_addr", s_addr, e_addr);
                chk("mdl_s_wdata", s_wdata, e_wdata);
                chk("mdl_s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
            end
        end
    end

    bit          auto_on = 0, cont = 0, quiesce = 0, rec = 0;
    int          rc0 = 0, rc1 = 0;
    logic [1:0]  prev_g = 2'b00;
    logic [1:0]  gq [$];

    task automatic new_req(input int i);
        mv[i] = 1'b1;
        ma[i] = $urandom;
        mw[i] = $urandom;
        ms[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endtask

    task automatic drive_auto();
        for (int i = 0; i < 2; i++) begin
            if (mv[i] && mrdy[i]) begin
                if (!quiesce && (cont || $urandom_range(0, 2) == 0)) new_req(i);
                else mv[i] = 1'b0;
            end else if (!mv[i]) begin
                if (!quiesce && (cont || $urandom_range(0, 3) == 0)) new_req(i);
            end else if ($urandom_range(0, 3) == 0) begin
                ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom);
            end
        end
        if (s_valid && !s_ready)       s_ready = ($urandom_range(0, 1) == 1);
        else if (!s_valid && !cont)    s_ready = ($urandom_range(0, 7) == 0);
        else                           s_ready = 1'b0;
        s_rdata = $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        if (rec) begin
            if (grant != 2'b00 && prev_g == 2'b00) gq.push_back(grant);
            if (m0_ready) rc0++;
            if (m1_ready) rc1++;
        end
        prev_g = grant;
        if (auto_on) drive_auto();
    endtask

    task automatic drain();
        int k;
        quiesce = 1; cont = 0; auto_on = 1;
        for (k = 0; k < 500; k++) begin
            step();
            if (mv == 2'b00 && !s_valid && grant == 2'b00) break;
        end
        auto_on = 0; quiesce = 0; s_ready = 1'b0;
        chk("drain_idle", {28'h0, mv, grant}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin ma[i] = 0; mw[i] = 0; ms[i] = 0; end
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ready", 32'(mrdy), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        resetn = 1'b1;

        // M0 read, 1-cycle slave
        mv[0] = 1'b1; ma[0] = 32'h0000_1000; mw[0] = $urandom; ms[0] = 4'h0;
        step();
        chk("t1_c1_s_valid", 32'(s_valid), 32'h1);
        chk("t1_c1_grant", 32'(grant), 32'h1);
        chk("t1_c1_s_addr", s_addr, 32'h0000_1000);
        step();
        chk("t1_c2_s_valid", 32'(s_valid), 32'h1);
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        step();
        chk("t1_c3_m0_ready", 32'(m0_ready), 32'h1);
        chk("t1_c3_m1_ready", 32'(m1_ready), 32'h0);
        chk("t1_c3_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        chk("t1_c3_grant", 32'(grant), 32'h1);
        chk("t1_c3_s_valid", 32'(s_valid), 32'h0);
        s_ready = 1'b0; mv[0] = 1'b0;
        step();
        chk("t1_c4_m0_ready", 32'(m0_ready), 32'h0);
        chk("t1_c4_grant", 32'(grant), 32'h0);

        // M1 write; its fields change after grant and must not leak through
        mv[1] = 1'b1; ma[1] = 32'h0000_2004; mw[1] = 32'h0000_A5A5; ms[1] = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t2_s_valid", 32'(s_valid), 32'h1);
            chk("t2_s_addr", s_addr, 32'h0000_2004);
            chk("t2_s_wdata", s_wdata, 32'h0000_A5A5);
            chk("t2_s_wstrb", 32'(s_wstrb), 32'h3);
            ma[1] = $urandom; mw[1] = $urandom; ms[1] = 4'($urandom);
        end
        s_ready = 1'b1; s_rdata = 32'h1357_9BDF;
        step();
        chk("t2_m1_ready", 32'(mrdy), 32'h2);
        chk("t2_m1_rdata", m1_rdata, 32'h1357_9BDF);
        s_ready = 1'b0; mv[1] = 1'b0;
        step();
        chk("t2_m1_ready_drop", 32'(mrdy), 32'h0);

        // Both masters request continuously from reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        rec = 1; cont = 1; auto_on = 1; prev_g = grant;
        new_req(0); new_req(1);
        for (int k = 0; k < 300 && (rc0 + rc1) < 6; k++) step();
        rec = 0;
        chk("t3_ready_total", 32'(rc0 + rc1), 32'd6);
        chk("t3_m0_readies", 32'(rc0), 32'd3);
        chk("t3_m1_readies", 32'(rc1), 32'd3);
        chk("t3_grant_count", 32'(gq.size()), 32'd6);
        for (int g = 0; g < gq.size() && g < 6; g++)
            chk($sformatf("t3_grant_%0d", g), 32'(gq[g]), (g % 2 == 0) ? 32'h1 : 32'h2);
        drain();

        // Reset while BUSY with M1 also pending
        mv[0] = 1'b1; ma[0] = 32'h0000_1ABC; ms[0] = 4'h0; s_ready = 1'b0;
        step(); step();
        mv[1] = 1'b1; ma[1] = 32'h0000_1F00; mw[1] = 32'h1234_5678; ms[1] = 4'hF;
        step();
        chk("t4_busy_s_valid", 32'(s_valid), 32'h1);
        chk("t4_busy_grant", 32'(grant), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("t4_rst_s_valid", 32'(s_valid), 32'h0);
        chk("t4_rst_grant", 32'(grant), 32'h0);
        chk("t4_rst_ready", 32'(mrdy), 32'h0);
        mv[0] = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("t4_m1_first_grant", 32'(grant), 32'h2);
        chk("t4_m1_s_addr", s_addr, 32'h0000_1F00);
        chk("t4_m1_s_wdata", s_wdata, 32'h1234_5678);
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        step();
        chk("t4_m1_ready", 32'(mrdy), 32'h2);
        chk("t4_m1_rdata", m1_rdata, 32'h0BAD_F00D);
        s_ready = 1'b0; mv[1] = 1'b0;
        step();

        // Spurious s_ready while idle
        for (int c = 0; c < 5; c++) begin
            s_ready = 1'b1; s_rdata = $urandom;
            step();
            chk("t5_no_ready", 32'(mrdy), 32'h0);
            chk("t5_no_s_valid", 32'(s_valid), 32'h0);
            chk("t5_no_grant", 32'(grant), 32'h0);
        end
        s_ready = 1'b0;
        step();

        // Silent slave: access waits indefinitely
        mv[0] = 1'b1; ma[0] = 32'h0000_1FFC; ms[0] = 4'h0;
        step();
        for (int c = 0; c < 200; c++) begin
            chk("t6_wait_s_valid", 32'(s_valid), 32'h1);
            chk("t6_wait_no_ready", 32'({timeout_err, mrdy}), 32'h0);
            step();
        end
        s_ready = 1'b1; s_rdata = 32'h2468_ACE0;
        step();
        chk("t6_late_ready", 32'(mrdy), 32'h1);
        chk("t6_late_rdata", m0_rdata, 32'h2468_ACE0);
        s_ready = 1'b0; mv[0] = 1'b0;
        step();

        // Randomized traffic, checked every cycle by the model
        cont = 0; auto_on = 1;
        repeat (3000) step();
        drain();

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
